// File: rtl/wb_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_seq
// Brief    : Registered write-back source selector. Waits for multi-cycle
//            sources, then issues a one-cycle register-file write.
// Revision : 1.0 - initial release
// ============================================================================

module wb_select_seq #(
    parameter int DATA_W        = 32,
    parameter int N_SRC         = 7,
    parameter int SEL_W         = 3,
    parameter int CONST_SEL     = 7,
    parameter int CONST_VAL     = 227,
    parameter int ADDR_W        = 5,
    parameter int TIMEOUT       = 64,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic [SEL_W-1:0]        sel,
    input  logic [ADDR_W-1:0]       dest,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic [ADDR_W-1:0]   r_dest, w_dest_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic                r_terr, w_terr_nxt;
    logic [DATA_W:0]     w_req_src;
    logic [DATA_W:0]     w_wait_src;

    // Returns {valid, data} for a selector code; unused codes read as valid zero.
    function automatic logic [DATA_W:0] f_eff_src(
        input logic [SEL_W-1:0]        s,
        input logic [N_SRC*DATA_W-1:0] d,
        input logic [N_SRC-1:0]        v
    );
        logic [DATA_W:0] res;
        if (s == SEL_W'(CONST_SEL))
            res = {1'b1, DATA_W'(CONST_VAL)};
        else
            res = {1'b1, {DATA_W{1'b0}}};
        for (int i = 0; i < N_SRC; i++) begin
            if (s == SEL_W'(i))
                res = {v[i], d[i*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    function automatic logic f_suppress(input logic [ADDR_W-1:0] a);
        return (ZERO_SUPPRESS != 0) && (a == '0);
    endfunction

    assign w_req_src  = f_eff_src(sel, src_data, src_valid);
    assign w_wait_src = f_eff_src(r_sel, src_data, src_valid);

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_dest_nxt    = r_dest;
        w_cnt_nxt     = r_cnt;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_terr_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_WRITE: begin
                if (req) begin
                    if (w_req_src[DATA_W]) begin
                        w_wr_data_nxt = w_req_src[DATA_W-1:0];
                        w_wr_addr_nxt = dest;
                        w_wr_en_nxt   = !f_suppress(dest);
                        w_state_nxt   = S_WRITE;
                    end else begin
                        w_sel_nxt   = sel;
                        w_dest_nxt  = dest;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                // A valid on the last counted cycle still beats the timeout.
                if (w_wait_src[DATA_W]) begin
                    w_wr_data_nxt = w_wait_src[DATA_W-1:0];
                    w_wr_addr_nxt = r_dest;
                    w_wr_en_nxt   = !f_suppress(r_dest);
                    w_state_nxt   = S_WRITE;
                end else if (r_cnt == c_cnt_last) begin
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_dest    <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_terr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_dest    <= w_dest_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_terr    <= w_terr_nxt;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign timeout_err = r_terr;
    assign busy        = (r_state == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_wb_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_select_seq
// Brief    : Directed self-checking bench for wb_select_seq.
// Revision : 1.0 - initial release
// ============================================================================

module tb_wb_select_seq;

    localparam int DATA_W = 32;
    localparam int N_SRC  = 7;
    localparam int SEL_W  = 3;
    localparam int ADDR_W = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    req;
    logic [SEL_W-1:0]        sel;
    logic [ADDR_W-1:0]       dest;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_valid;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    busy;
    logic                    timeout_err;

    int n_vec = 0;
    int n_err = 0;

    wb_select_seq dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .sel         (sel),
        .dest        (dest),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic set_src(input int idx, input logic [DATA_W-1:0] val);
        src_data[idx*DATA_W +: DATA_W] = val;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b0; sel = '0; dest = '0;
        src_data = '0; src_valid = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        n_vec++; if (wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        n_vec++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_direct;
        src_valid = 7'h7F;
        set_src(2, 32'hDEADBEEF);
        req = 1'b1; sel = 3'd2; dest = 5'd9;
        @(negedge clk);
        req = 1'b0;
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL direct_wr_en got %b exp 1", wr_en); end
        n_vec++; if (wr_addr !== 5'd9) begin n_err++; $display("FAIL direct_wr_addr got %0d exp 9", wr_addr); end
        n_vec++; if (wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL direct_wr_data got %h exp deadbeef", wr_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL direct_busy got %b exp 0", busy); end
        @(negedge clk);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL direct_pulse got %b exp 0", wr_en); end
        n_vec++; if (wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL direct_hold got %h exp deadbeef", wr_data); end
    endtask

    task automatic test_const;
        src_valid = '0;
        req = 1'b1; sel = 3'd7; dest = 5'd4;
        @(negedge clk);
        req = 1'b0;
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL const_wr_en got %b exp 1", wr_en); end
        n_vec++; if (wr_addr !== 5'd4) begin n_err++; $display("FAIL const_wr_addr got %0d exp 4", wr_addr); end
        n_vec++; if (wr_data !== 32'h000000E3) begin n_err++; $display("FAIL const_wr_data got %h exp 000000e3", wr_data); end
        @(negedge clk);
    endtask

    task automatic test_wait;
        int busy_cnt = 0;
        int extra_wr = 0;
        src_valid = 7'h00;
        set_src(5, 32'h0BADF00D);
        req = 1'b1; sel = 3'd5; dest = 5'd3;
        @(negedge clk);
        // Requests raised while waiting must be ignored.
        req = 1'b1; sel = 3'd2; dest = 5'd7; src_valid = 7'h5F;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (wr_en !== 1'b0) extra_wr++;
            if (i < 9) @(negedge clk);
        end
        n_vec++; if (busy_cnt !== 10) begin n_err++; $display("FAIL wait_busy_cycles got %0d exp 10", busy_cnt); end
        n_vec++; if (extra_wr !== 0) begin n_err++; $display("FAIL wait_no_write got %0d exp 0", extra_wr); end
        req = 1'b0;
        src_valid = 7'h7F;
        set_src(5, 32'h12345678);
        @(negedge clk);
        set_src(5, 32'hFFFF0000);
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL wait_wr_en got %b exp 1", wr_en); end
        n_vec++; if (wr_addr !== 5'd3) begin n_err++; $display("FAIL wait_wr_addr got %0d exp 3", wr_addr); end
        n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL wait_wr_data got %h exp 12345678", wr_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_busy_after got %b exp 0", busy); end
        @(negedge clk);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL wait_pulse got %b exp 0", wr_en); end
        n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL wait_capture got %h exp 12345678", wr_data); end
    endtask

    task automatic test_timeout;
        int busy_cnt = 0;
        int terr_cnt = 0;
        int wr_cnt   = 0;
        int terr_at  = -1;
        src_valid = 7'h00;
        req = 1'b1; sel = 3'd1; dest = 5'd6;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (timeout_err === 1'b1) begin terr_cnt++; terr_at = i; end
            if (wr_en !== 1'b0) wr_cnt++;
            @(negedge clk);
        end
        n_vec++; if (busy_cnt !== 64) begin n_err++; $display("FAIL tmo_busy_cycles got %0d exp 64", busy_cnt); end
        n_vec++; if (terr_cnt !== 1) begin n_err++; $display("FAIL tmo_err_pulses got %0d exp 1", terr_cnt); end
        n_vec++; if (terr_at !== 65) begin n_err++; $display("FAIL tmo_err_cycle got %0d exp 65", terr_at); end
        n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL tmo_no_write got %0d exp 0", wr_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle got %b exp 0", busy); end

        // Valid rises on the last WAIT cycle: write wins over timeout.
        busy_cnt = 0;
        req = 1'b1; sel = 3'd1; dest = 5'd6;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (i < 64) @(negedge clk);
        end
        src_valid = 7'h02;
        set_src(1, 32'hCAFE0001);
        @(negedge clk);
        n_vec++; if (busy_cnt !== 64) begin n_err++; $display("FAIL late_busy_cycles got %0d exp 64", busy_cnt); end
        n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL late_wr_en got %b exp 1", wr_en); end
        n_vec++; if (wr_data !== 32'hCAFE0001) begin n_err++; $display("FAIL late_wr_data got %h exp cafe0001", wr_data); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL late_terr got %b exp 0", timeout_err); end
        @(negedge clk);
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL late_terr_next got %b exp 0", timeout_err); end
        src_valid = '0;
    endtask

    task automatic test_back_to_back;
        src_valid = 7'h7F;
        set_src(0, 32'hA1A1A1A1);
        set_src(3, 32'hB2B2B2B2);
        set_src(4, 32'hC3C3C3C3);
        req = 1'b1; sel = 3'd0; dest = 5'd1;
        @(negedge clk);
        n_vec++; if ({wr_en, wr_addr} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL b2b_0_en_addr got %b/%0d exp 1/1", wr_en, wr_addr); end
        n_vec++; if (wr_data !== 32'hA1A1A1A1) begin n_err++; $display("FAIL b2b_0_data got %h exp a1a1a1a1", wr_data); end
        sel = 3'd3; dest = 5'd2;
        @(negedge clk);
        n_vec++; if ({wr_en, wr_addr} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL b2b_1_en_addr got %b/%0d exp 1/2", wr_en, wr_addr); end
        n_vec++; if (wr_data !== 32'hB2B2B2B2) begin n_err++; $display("FAIL b2b_1_data got %h exp b2b2b2b2", wr_data); end
        sel = 3'd4; dest = 5'd0;
        @(negedge clk);
        req = 1'b0;
        n_vec++; if ({wr_en, wr_addr} !== {1'b0, 5'd0}) begin n_err++; $display("FAIL b2b_2_en_addr got %b/%0d exp 0/0", wr_en, wr_addr); end
        n_vec++; if (wr_data !== 32'hC3C3C3C3) begin n_err++; $display("FAIL b2b_2_data got %h exp c3c3c3c3", wr_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b exp 0", busy); end
        @(negedge clk);
        n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", wr_en); end
    endtask

    task automatic test_reset_mid_wait;
        int wr_cnt = 0;
        int busy_cnt = 0;
        src_valid = 7'h00;
        req = 1'b1; sel = 3'd5; dest = 5'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
        #1 reset = 1'b0;
        #1;
        n_vec++; if ({wr_en, busy, timeout_err} !== 3'b000) begin n_err++; $display("FAIL rst_async_ctl got %b exp 000", {wr_en, busy, timeout_err}); end
        n_vec++; if (wr_addr !== '0) begin n_err++; $display("FAIL rst_async_addr got %0d exp 0", wr_addr); end
        n_vec++; if (wr_data !== '0) begin n_err++; $display("FAIL rst_async_data got %h exp 0", wr_data); end
        src_valid = 7'h7F;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b0) wr_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL rst_no_write got %0d exp 0", wr_cnt); end
        n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL rst_busy_after got %0d exp 0", busy_cnt); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_const();
        test_wait();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_select_seq.md
Name: wb_select_seq

Overview:
- Parametrised, registered successor to the combinational write-data selector of the multicycle core.
- Selects one of N_SRC write-back sources, or a built-in constant, for a register-file write.
- Waits for multi-cycle sources (mult/div, memory) to raise valid, then issues a one-cycle register-file write.
- Sits between the datapath sources and the register-file write port; `busy` stalls the control unit.

Parameters:
- DATA_W, 32: data width of every source and of `wr_data`.
- N_SRC, 7: number of external sources.
- SEL_W, 3: selector width; must satisfy 2^SEL_W > N_SRC.
- CONST_SEL, 7: selector code that selects the constant; must be >= N_SRC.
- CONST_VAL, 227: constant value, zero-extended to DATA_W.
- ADDR_W, 5: destination register address width.
- TIMEOUT, 64: maximum cycles spent in WAIT before aborting; must be >= 2.
- ZERO_SUPPRESS, 1: 1 means a write to address 0 is suppressed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  write-back request; sampled only when `busy` = 0.
- sel  input  SEL_W  source select for `req`.
- dest  input  ADDR_W  destination register for `req`.
- src_data  input  N_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- src_valid  input  N_SRC  bit i = 1 means source i data is valid this cycle.
- wr_en  output  1  register-file write enable, one-cycle pulse.
- wr_addr  output  ADDR_W  register-file write address.
- wr_data  output  DATA_W  register-file write data.
- busy  output  1  request pending in WAIT; control unit must hold.
- timeout_err  output  1  one-cycle pulse when a WAIT is aborted.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, wait counter = 0, latched sel/dest = 0.
  - Outputs: wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, timeout_err = 0.
  - Reset asserted mid-WAIT or mid-WRITE aborts the operation with no write.
- Effective source for selector value s:
  - s < N_SRC: data = src_data slice s, valid = src_valid[s].
  - s == CONST_SEL: data = CONST_VAL, always valid.
  - any other s: data = 0, always valid.
- States: IDLE, WAIT, WRITE.
- IDLE:
  - req = 1 and effective source valid: capture data, dest -> wr_data, wr_addr; go to WRITE. Latency is exactly 1 cycle from req to wr_en.
  - req = 1 and source not valid: latch sel and dest, clear counter, go to WAIT.
  - req = 0: stay in IDLE; wr_data and wr_addr hold their last values.
- WAIT:
  - busy = 1; req is ignored.
  - Each cycle, the latched sel is re-evaluated against current src_valid.
  - Source valid: capture the current data, go to WRITE.
  - Source not valid: counter increments.
  - Counter == TIMEOUT-1 and source still not valid: go to IDLE, assert timeout_err for 1 cycle, no write.
  - Valid arriving in the same cycle the counter reaches TIMEOUT-1: valid wins, and the write proceeds.
- WRITE:
  - wr_en = 1 for exactly one cycle, except when ZERO_SUPPRESS = 1 and wr_addr == 0; then wr_en = 0, but the state still passes through WRITE.
  - busy = 0 and req is accepted exactly as in IDLE. Back-to-back requests therefore sustain one write per cycle when sources are valid.
  - With no req: next state is IDLE.
- wr_en, wr_addr, wr_data and timeout_err are registered outputs; busy is decoded from state.
- Source data is captured on the valid cycle. Later changes on src_data do not affect wr_data.

Test Plan:
1. Reset released; req = 1, sel = 2, dest = 9, src_valid = 7'h7F, source 2 = 32'hDEADBEEF -> next cycle wr_en = 1, wr_addr = 9, wr_data = 32'hDEADBEEF, busy = 0; the following cycle wr_en = 0.
2. req, sel = 7, dest = 4 with all src_valid = 0 -> 1 cycle later wr_en = 1, wr_data = 227 (32'h000000E3).
3. req, sel = 5, dest = 3, src_valid[5] = 0 for 10 cycles, then 1 with data 32'h12345678 -> busy = 1 for 10 cycles, then wr_en = 1 with wr_data = 32'h12345678 one cycle after valid; a req issued during WAIT causes no extra write.
4. req, sel = 1, src_valid[1] held 0, TIMEOUT = 64 -> busy high for 64 cycles, timeout_err pulses once, wr_en never asserted, state returns to IDLE; repeat with valid rising on the final WAIT cycle -> write occurs and timeout_err stays 0.
5. Back-to-back: req held for 3 cycles with dests 1, 2, 0, all sources valid, ZERO_SUPPRESS = 1 -> wr_en = 1, 1, 0 on three consecutive cycles with correct wr_addr/wr_data.
6. Assert reset in the third WAIT cycle -> all outputs 0 immediately (asynchronously); after release there is no write and busy = 0.
